// File: rtl/uart_tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter:
//   state_t            - arbiter FSM states (IDLE, LOAD, WAIT_FRAME, GAP)
//   UART_DATA_W        - byte width handed to the UART core
//   DEFAULT_FRAME_BITS - start + 8 data + parity + stop
//   cnt_width()        - width of the single frame/gap down-counter
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      LOAD       = 2'd1,
      WAIT_FRAME = 2'd2,
      GAP        = 2'd3
   } state_t;

   localparam int UART_DATA_W        = 8;
   localparam int DEFAULT_FRAME_BITS = 11;

   // The counter only ever holds (cycles - 1), so $clog2 of the larger
   // interval is enough; keep at least one bit for degenerate settings.
   function automatic int cnt_width(input int clks_per_bit,
                                    input int frame_bits,
                                    input int gap_bits);
      int frame_cycles;
      int gap_cycles;
      int max_cycles;
      frame_cycles = clks_per_bit * frame_bits;
      gap_cycles   = clks_per_bit * gap_bits;
      max_cycles   = (frame_cycles > gap_cycles) ? frame_cycles : gap_cycles;
      return (max_cycles < 2) ? 1 : $clog2(max_cycles);
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. Searches req starting at ptr+1 (modulo
// N_REQ) and returns the first set bit.
//   req   in  N_REQ   request vector
//   ptr   in  IDX_W   index of the previous winner
//   grant out N_REQ   one-hot winner (all zero when nothing requested)
//   idx   out IDX_W   binary index of the winner
//   any   out 1       at least one request present
// Build option UART_TX_ARB_PRIORITY_EN: requester 0 always wins when it
// requests; the remaining requesters rotate among themselves.
// -----------------------------------------------------------------------------
module rr_picker
   import uart_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
)(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Requests that take part in the rotating search.
   logic [N_REQ-1:0] req_m;

`ifdef UART_TX_ARB_PRIORITY_EN
   // Requester 0 is served by the fixed-priority path below, never by rotation.
   assign req_m = {req[N_REQ-1:1], 1'b0};
`else
   assign req_m = req;
`endif

   always_comb begin
      int cand;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = 0;
`ifdef UART_TX_ARB_PRIORITY_EN
      if (req[0]) begin
         grant[0] = 1'b1;
         any      = 1'b1;
      end
`endif
      // k runs 1..N_REQ so ptr itself is considered last.
      for (int k = 1; k <= N_REQ; k++) begin
         cand = (int'(ptr) + k) % N_REQ;
         if (!any && req_m[cand]) begin
            grant[cand] = 1'b1;
            idx         = IDX_W'(cand);
            any         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between N_REQ byte sources. A winner is chosen
// round-robin in IDLE, its byte is registered onto data_in, tx_en pulses the
// next cycle, and further grants are held off for one frame time plus an
// inter-frame gap (the UART core has no tx-done status, so frames are timed
// here).
// Ports:
//   clk        in  1            system clock
//   reset      in  1            asynchronous, active-low reset
//   enable     in  1            low: no new grants (in-flight frame completes)
//   req_valid  in  N_REQ        per-requester byte available
//   req_data   in  8*N_REQ      byte for requester i at [8i+7:8i]
//   req_ready  out N_REQ        one-hot, one-cycle accept pulse
//   tx_en      out 1            one-cycle start pulse to UART core
//   data_in    out 8            byte to UART core
//   busy       out 1            high whenever the FSM is not IDLE
//   grant_id   out clog2(N_REQ) index of the last accepted requester
//   frame_done out 1            pulse on the last cycle of frame time
// Build option UART_TX_ARB_PRIORITY_EN: requester 0 has fixed top priority.
// -----------------------------------------------------------------------------
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int CLKS_PER_BIT = 16,
   parameter int FRAME_BITS   = DEFAULT_FRAME_BITS,
   parameter int GAP_BITS     = 1
)(
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enable,
   input  logic [N_REQ-1:0]               req_valid,
   input  logic [UART_DATA_W*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]               req_ready,
   output logic                           tx_en,
   output logic [UART_DATA_W-1:0]         data_in,
   output logic                           busy,
   output logic [$clog2(N_REQ)-1:0]       grant_id,
   output logic                           frame_done
);

   localparam int IDX_W        = $clog2(N_REQ);
   localparam int FRAME_CYCLES = CLKS_PER_BIT * FRAME_BITS;
   localparam int GAP_CYCLES   = CLKS_PER_BIT * GAP_BITS;
   localparam int CNT_W        = cnt_width(CLKS_PER_BIT, FRAME_BITS, GAP_BITS);

   state_t                 state_reg, state_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic [UART_DATA_W-1:0] data_reg, data_next;
   logic [IDX_W-1:0]       gid_reg, gid_next;
   logic [IDX_W-1:0]       ptr_reg, ptr_next;
   // Cleared by reset and set on the first clock afterwards. It gates the
   // combinational accept so req_ready stays low for as long as reset is held,
   // even though the FSM sits in IDLE with requests pending.
   logic                   run_reg;

   logic [UART_DATA_W-1:0] req_bytes [N_REQ];
   logic [N_REQ-1:0]       pick_grant;
   logic [IDX_W-1:0]       pick_idx;
   logic                   pick_any;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
      assign req_bytes[gi] = req_data[gi*UART_DATA_W +: UART_DATA_W];
   end

   rr_picker #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .req   (req_valid),
      .ptr   (ptr_reg),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         data_reg  <= '0;
         gid_reg   <= '0;
         ptr_reg   <= IDX_W'(N_REQ - 1);
         run_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         data_reg  <= data_next;
         gid_reg   <= gid_next;
         ptr_reg   <= ptr_next;
         run_reg   <= 1'b1;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      data_next  = data_reg;
      gid_next   = gid_reg;
      ptr_next   = ptr_reg;
      req_ready  = '0;
      tx_en      = 1'b0;
      frame_done = 1'b0;

      case (state_reg)
         IDLE: begin
            if (run_reg && enable && pick_any) begin
               req_ready  = pick_grant;
               data_next  = req_bytes[pick_idx];
               gid_next   = pick_idx;
`ifdef UART_TX_ARB_PRIORITY_EN
               // Fixed-priority wins by requester 0 must not disturb the
               // rotation among the others.
               if (pick_idx != '0) begin
                  ptr_next = pick_idx;
               end
`else
               ptr_next   = pick_idx;
`endif
               state_next = LOAD;
            end
         end

         LOAD: begin
            tx_en      = 1'b1;
            cnt_next   = CNT_W'(FRAME_CYCLES - 1);
            state_next = WAIT_FRAME;
         end

         WAIT_FRAME: begin
            if (cnt_reg == '0) begin
               frame_done = 1'b1;
               if (GAP_CYCLES == 0) begin
                  state_next = IDLE;
               end else begin
                  cnt_next   = CNT_W'(GAP_CYCLES - 1);
                  state_next = GAP;
               end
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end

         GAP: begin
            if (cnt_reg == '0) begin
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign data_in  = data_reg;
   assign grant_id = gid_reg;
   assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter with CLKS_PER_BIT=4, FRAME_BITS=11,
// GAP_BITS=1, N_REQ=4. Expected grants (requester + byte) are queued when the
// stimulus is set up and popped when the DUT accepts.
// Honours UART_TX_ARB_PRIORITY_EN for the expected grant order.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int N   = 4;
   localparam int CPB = 4;
   localparam int FB  = 11;
   localparam int GB  = 1;
   localparam int FC  = CPB * FB;      // 44 frame cycles
   localparam int GC  = CPB * GB;      // 4 gap cycles
   // accept cycle + LOAD cycle + frame + gap, before the next accept
   localparam int PERIOD = FC + GC + 2;

   logic           clk       = 1'b0;
   logic           reset     = 1'b0;
   logic           enable    = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [8*N-1:0] req_data  = '0;
   logic [N-1:0]   req_ready;
   logic           tx_en;
   logic [7:0]     data_in;
   logic           busy;
   logic [1:0]     grant_id;
   logic           frame_done;

   int cyc   = 0;
   int total = 0;
   int bad   = 0;

   typedef struct {
      int         id;
      logic [7:0] data;
   } exp_t;
   exp_t sb[$];

   uart_tx_arbiter #(
      .N_REQ        (N),
      .CLKS_PER_BIT (CPB),
      .FRAME_BITS   (FB),
      .GAP_BITS     (GB)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .tx_en      (tx_en),
      .data_in    (data_in),
      .busy       (busy),
      .grant_id   (grant_id),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      total++;
      assert (obs === req) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, req);
      end
   endtask

   // Advance to the next falling edge; there req_ready must only name a
   // valid requester and must be quiet whenever the arbiter is busy.
   task automatic tick();
      @(negedge clk);
      chk("ready_legal", 32'(((req_ready & ~req_valid) != '0) || (busy && (req_ready != '0))), 0);
   endtask

   task automatic set_byte(input int i, input logic [7:0] b);
      req_data[8*i +: 8] = b;
   endtask

   task automatic push(input int id, input logic [7:0] d);
      exp_t e;
      e.id   = id;
      e.data = d;
      sb.push_back(e);
   endtask

   // Wait (up to budget cycles) for an accept, check it against the queue
   // head, then check the tx_en cycle that follows. Returns in the tx_en cycle.
   task automatic service(input int budget, output int tx_cyc);
      exp_t e;
      int   n;
      #1;
      n = 0;
      while (req_ready == '0 && n < budget) begin
         tick();
         #1;
         n++;
      end
      chk("grant_seen", 32'(req_ready != '0), 1);
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() == 0) begin
         tx_cyc = cyc;
         return;
      end
      e = sb.pop_front();
      chk("req_ready", 32'(req_ready), 32'(1 << e.id));
      tick();
      #1;
      tx_cyc = cyc;
      chk("tx_en", 32'(tx_en), 1);
      chk("data_in", 32'(data_in), 32'(e.data));
      chk("grant_id", 32'(grant_id), 32'(e.id));
      chk("ready_after_accept", 32'(req_ready), 0);
      $display("grant id=%0d data=%02h tx_en_cycle=%0d", e.id, e.data, tx_cyc);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         tick();
         #1;
         n++;
      end
      chk("idle_reached", 32'(busy), 0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      #1;
      reset = 1'b1;
   endtask

   initial begin
      int t_tx;
      int prev_tx;
      int n;

      // ---------------- reset state ----------------
      req_valid = 4'b1111;
      tick(); tick(); tick();
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_tx_en", 32'(tx_en), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_data_in", 32'(data_in), 0);
      chk("rst_grant_id", 32'(grant_id), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      req_valid = '0;
      reset = 1'b1;

      // ---------------- single request: requester 2, 8'hA5 ----------------
      set_byte(2, 8'hA5);
      req_valid = 4'b0100;
      push(2, 8'hA5);
      service(20, t_tx);
      req_valid = '0;
      n = 0;
      while (!frame_done && n < 100) begin
         tick(); #1; n++;
      end
      chk("frame_done_delay", 32'(n), FC);
      tick(); #1;
      chk("frame_done_pulse", 32'(frame_done), 0);
      n = 1;
      while (busy && n < 100) begin
         tick(); #1; n++;
      end
      chk("busy_low_delay", 32'(n), GC + 1);

      // ---------------- all four valid continuously ----------------
      do_reset();
      for (int i = 0; i < N; i++) set_byte(i, 8'(8'h10 + i));
      req_valid = 4'b1111;
`ifdef UART_TX_ARB_PRIORITY_EN
      push(0, 8'h10); push(0, 8'h20); push(0, 8'h30); push(0, 8'h40); push(0, 8'h50);
`else
      push(0, 8'h10); push(1, 8'h11); push(2, 8'h12); push(3, 8'h13); push(0, 8'h20);
`endif
      prev_tx = 0;
      for (int k = 0; k < 5; k++) begin
         service(PERIOD + 10, t_tx);
         if (k > 0) chk("tx_spacing", 32'(t_tx - prev_tx), PERIOD);
         prev_tx = t_tx;
         // The requester just served offers a fresh byte.
         set_byte(int'(grant_id), 8'(req_data[8*int'(grant_id) +: 8] + 8'h10));
      end
      req_valid = '0;
      wait_idle(100);

      // ---------------- requester 2 drops while 1 transmits ----------------
      do_reset();
      set_byte(1, 8'hB1); set_byte(2, 8'hB2); set_byte(3, 8'hB3);
      req_valid = 4'b1110;
      push(1, 8'hB1);
      service(20, t_tx);
      req_valid = 4'b1100;
      for (int i = 0; i < 20; i++) tick();
      #1;
      req_valid = 4'b1000;
      push(3, 8'hB3);
      service(PERIOD + 10, t_tx);
      req_valid = '0;
      wait_idle(100);

      // ---------------- reset 20 cycles into WAIT_FRAME ----------------
      set_byte(0, 8'hC0); set_byte(1, 8'hC1); set_byte(2, 8'hC2); set_byte(3, 8'hC3);
      req_valid = 4'b1110;
      push(1, 8'hC1);
      service(20, t_tx);
      req_valid = 4'b1111;
      for (int i = 0; i < 20; i++) tick();
      #1;
      chk("mid_frame_busy", 32'(busy), 1);
      reset = 1'b0;
      #1;
      chk("async_rst_busy", 32'(busy), 0);
      chk("async_rst_tx_en", 32'(tx_en), 0);
      chk("async_rst_req_ready", 32'(req_ready), 0);
      chk("async_rst_data_in", 32'(data_in), 0);
      chk("async_rst_grant_id", 32'(grant_id), 0);
      chk("async_rst_frame_done", 32'(frame_done), 0);
      tick(); tick();
      #1;
      reset = 1'b1;
      push(0, 8'hC0);
      service(5, t_tx);
      req_valid = '0;
      wait_idle(100);

      // ---------------- enable low with requests pending ----------------
      enable    = 1'b0;
      req_valid = 4'b1111;
      for (int i = 0; i < 100; i++) begin
         tick();
         #1;
         chk("en_low_ready", 32'(req_ready), 0);
         chk("en_low_tx_en", 32'(tx_en), 0);
      end
      enable = 1'b1;
`ifdef UART_TX_ARB_PRIORITY_EN
      push(0, 8'hC0);
`else
      push(1, 8'hC1);
`endif
      service(0, t_tx);
      req_valid = '0;
      wait_idle(100);

`ifdef UART_TX_ARB_PRIORITY_EN
      // ---------------- rotation among 1..3 with requester 0 idle ----------------
      do_reset();
      req_valid = 4'b1110;
      push(1, 8'hC1); push(2, 8'hC2); push(3, 8'hC3);
      for (int k = 0; k < 3; k++) service(PERIOD + 10, t_tx);
      req_valid = '0;
      wait_idle(100);
`endif

      chk("sb_drained", 32'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
